gsim_param_solver: RTL

//  Parametrised Gauss-Seidel solver for the N x N banded symmetric Toeplitz system
//  A*x = b, with row coefficients -1, 6, -13, 20, -13, 6, -1. Out-of-range terms are 0.

---
 rtl/gsim_pkg.sv | 16 +
 rtl/gsim_row_update.sv | 64 ++++++
 rtl/gsim_param_solver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the parametrised Gauss-Seidel solver.
package gsim_pkg;

  // Off-diagonal magnitudes at distance 1, 2 and 3, and the diagonal term.
  localparam int COEF1   = 13;
  localparam int COEF2   = 6;
  localparam int COEF3   = 1;
  localparam int DIAG    = 20;

  // 1/DIAG as a 2^-RSH fixed-point reciprocal (52429 / 2^20 ~= 0.05).
  localparam int RECIP20 = 52429;
  localparam int RSH     = 20;

  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, OUT} state_t;

endpackage

// File: rtl/gsim_row_update.sv
// One Gauss-Seidel row update: builds the row sum, scales it by 1/20 with
// round-half-up, saturates it to the x format and reports |x_new - x_old|.
module gsim_row_update
  import gsim_pkg::*;
#(
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16
) (
  input  logic signed [BW-1:0] b_i,
  input  logic signed [XW-1:0] xm1,
  input  logic signed [XW-1:0] xm2,
  input  logic signed [XW-1:0] xm3,
  input  logic signed [XW-1:0] xp1,
  input  logic signed [XW-1:0] xp2,
  input  logic signed [XW-1:0] xp3,
  input  logic signed [XW-1:0] x_old,
  output logic signed [XW-1:0] x_new,
  output logic        [XW:0]   abs_dx
);

  localparam int AW = XW + 6;
  localparam int PW = AW + 18;
  localparam int QW = PW - RSH;
  localparam int DW = XW + 1;

  logic signed [AW-1:0] s;
  logic signed [PW-1:0] p;
  logic signed [QW-1:0] q;
  logic signed [DW-1:0] dx;

  function automatic logic signed [QW-1:0] round_shift(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t = v + (PW'(1) <<< (RSH - 1));
    return t[PW-1:RSH];
  endfunction

  function automatic logic signed [XW-1:0] sat_x(input logic signed [QW-1:0] v);
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    hi = {{(QW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    lo = {{(QW-XW+1){1'b1}}, {(XW-1){1'b0}}};
    if (v > hi)
      return {1'b0, {(XW-1){1'b1}}};
    else if (v < lo)
      return {1'b1, {(XW-1){1'b0}}};
    else
      return v[XW-1:0];
  endfunction

  // Row sum, reciprocal scaling, saturation and delta magnitude.
  always_comb begin
    s = (AW'(b_i) <<< FRAC)
      + AW'(COEF1) * (AW'(xm1) + AW'(xp1))
      - AW'(COEF2) * (AW'(xm2) + AW'(xp2))
      + AW'(COEF3) * (AW'(xm3) + AW'(xp3));
    p      = PW'(s) * PW'(RECIP20);
    q      = round_shift(p);
    x_new  = sat_x(q);
    dx     = DW'(x_new) - DW'(x_old);
    abs_dx = dx[XW] ? -dx : dx;
  end

endmodule

// File: rtl/gsim_param_solver.sv
// Gauss-Seidel solver for the banded Toeplitz system (-1,6,-13,20,-13,6,-1):
// loads N b values, sweeps one row per cycle until the max update falls within
// TOL or MAX_IT sweeps have run, then streams x[0..N-1].
module gsim_param_solver
  import gsim_pkg::*;
#(
  parameter int N      = 16,
  parameter int BW     = 16,
  parameter int XW     = 32,
  parameter int FRAC   = 16,
  parameter int MAX_IT = 64,
  parameter int TOL    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_en,
  input  logic [BW-1:0]                b_in,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [XW-1:0]                x_out,
  output logic                         busy,
  output logic                         conv,
  output logic [$clog2(MAX_IT+1)-1:0]  iter_cnt
);

  localparam int IW  = $clog2(N + 1);
  localparam int ITW = $clog2(MAX_IT + 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic signed [BW-1:0] b_mem [N];
  logic signed [XW-1:0] x_mem [N];
  logic [XW-1:0]        dmax;

  logic signed [BW-1:0] b_cur;
  logic signed [XW-1:0] x_cur;
  logic signed [XW-1:0] xm1, xm2, xm3, xp1, xp2, xp3;
  logic signed [XW-1:0] x_new;
  logic [XW:0]          abs_dx;
  logic [XW-1:0]        dx_clip;
  logic [XW-1:0]        dmax_new;
  logic                 sweep_end;
  logic                 converged;
  logic                 last_it;

  // Select the current row and its neighbours; rows outside 0..N-1 read as 0.
  always_comb begin
    b_cur = '0;
    x_cur = '0;
    xm1 = '0; xm2 = '0; xm3 = '0;
    xp1 = '0; xp2 = '0; xp3 = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx)) begin
        b_cur = b_mem[j];
        x_cur = x_mem[j];
      end
      if (j == int'(idx) - 1) xm1 = x_mem[j];
      if (j == int'(idx) - 2) xm2 = x_mem[j];
      if (j == int'(idx) - 3) xm3 = x_mem[j];
      if (j == int'(idx) + 1) xp1 = x_mem[j];
      if (j == int'(idx) + 2) xp2 = x_mem[j];
      if (j == int'(idx) + 3) xp3 = x_mem[j];
    end
  end

  gsim_row_update #(.BW(BW), .XW(XW), .FRAC(FRAC)) u_row (
    .b_i    (b_cur),
    .xm1    (xm1),
    .xm2    (xm2),
    .xm3    (xm3),
    .xp1    (xp1),
    .xp2    (xp2),
    .xp3    (xp3),
    .x_old  (x_cur),
    .x_new  (x_new),
    .abs_dx (abs_dx)
  );

  // Running sweep maximum of |dx| (clipped into XW bits) and end-of-sweep decisions.
  always_comb begin
    dx_clip   = abs_dx[XW] ? '1 : abs_dx[XW-1:0];
    dmax_new  = (dx_clip > dmax) ? dx_clip : dmax;
    sweep_end = (int'(idx) == N - 1);
    converged = (TOL != 0) && (dmax_new <= XW'(TOL));
    last_it   = (iter_cnt == ITW'(MAX_IT - 1));
  end

  // Control FSM with registered outputs, register files and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_out     <= '0;
      busy      <= 1'b0;
      conv      <= 1'b0;
      iter_cnt  <= '0;
      dmax      <= '0;
      for (int j = 0; j < N; j++) begin
        b_mem[j] <= '0;
        x_mem[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_en) begin
            b_mem[0] <= b_in;
            for (int j = 0; j < N; j++) x_mem[j] <= '0;
            conv     <= 1'b0;
            iter_cnt <= '0;
            idx      <= IW'(1);
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_en) begin
            for (int j = 0; j < N; j++)
              if (j == int'(idx)) b_mem[j] <= b_in;
            if (int'(idx) == N - 1) begin
              idx      <= '0;
              dmax     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= SOLVE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        SOLVE: begin
          for (int j = 0; j < N; j++)
            if (j == int'(idx)) x_mem[j] <= x_new;
          if (sweep_end) begin
            iter_cnt <= iter_cnt + ITW'(1);
            idx      <= '0;
            dmax     <= '0;
            if (converged) begin
              conv  <= 1'b1;
              state <= OUT;
            end else if (last_it) begin
              state <= OUT;
            end
          end else begin
            idx  <= idx + IW'(1);
            dmax <= dmax_new;
          end
        end
        OUT: begin
          if (int'(idx) == N) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            idx       <= '0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
            x_out     <= x_cur;
            idx       <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
